mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single SRAM-like memory port of the CPU core between the fetch-stage
//  instruction requester and the mem-stage data requester. At most one transaction
//  is outstanding at a time. Data requests have priority over instruction requests.
//  A starvation counter forces an instruction grant after a run of data grants.
//  Sits between the datapath/stall logic and the AXI bridge.
// PARAMETERS
//  AW          32  address width
//  DW          32  data width
//  STARVE_MAX  4   consecutive data grants while inst_req is pending before inst is forced
// PORTS
//  clk           in   1   clock, rising edge
//  rst           in   1   asynchronous reset, active-high
//  inst_req      in   1   instruction read request; held until inst_addr_ok
//  inst_addr     in   AW  instruction address
//  inst_addr_ok  out  1   instruction request accepted (1-cycle pulse)
//  inst_data_ok  out  1   instruction read data valid (1-cycle pulse)
//  inst_rdata    out  DW  instruction read data
//  data_req      in   1   data request; held until data_addr_ok
//  data_wr       in   1   1 = write, 0 = read
//  data_size     in   2   0 = byte, 1 = half, 2 = word
//  data_addr     in   AW  data address
//  data_wdata    in   DW  write data
//  data_addr_ok  out  1   data request accepted (1-cycle pulse)
//  data_data_ok  out  1   data response: read data valid or write done (1-cycle pulse)
//  data_rdata    out  DW  data read data
//  mem_req       out  1   memory request
//  mem_wr        out  1   memory write enable
//  mem_size      out  2   memory access size
//  mem_addr      out  AW  memory address
//  mem_wdata     out  DW  memory write data
//  mem_addr_ok   in   1   memory accepted the request
//  mem_data_ok   in   1   memory response
//  mem_rdata     in   DW  memory read data
//  busy          out  1   1 whenever state != IDLE
// BEHAVIOUR
//  States: IDLE, ADDR, WAIT. Owner register: owner = 0 (inst) or 1 (data).
//  Reset: state = IDLE, owner = 0, starve_cnt = 0.
//   All mem_* outputs = 0. All *_ok outputs = 0. Both rdata outputs = 0. busy = 0.
//  IDLE, grant rule:
//   - Force inst if inst_req && starve_cnt == STARVE_MAX.
//   - Otherwise grant data if data_req; else grant inst if inst_req; else stay in IDLE.
//   - On a grant: latch addr/wr/size/wdata into the mem_* registers (inst grant:
//     wr = 0, size = 2, wdata = 0), set owner, go to ADDR.
//   - A request seen in cycle N gives mem_req = 1 in cycle N+1.
//  starve_cnt:
//   - Increments on a data grant while inst_req = 1, saturating at STARVE_MAX.
//   - Clears on any inst grant, and on a data grant while inst_req = 0.
//  ADDR:
//   - mem_req = 1; mem_* outputs come from registers and are stable until mem_addr_ok.
//   - On mem_addr_ok: owner's addr_ok = mem_addr_ok (combinational, same cycle).
//     mem_req drops to 0 the next cycle.
//   - Next state is WAIT, or IDLE if mem_data_ok is also asserted in that cycle.
//  WAIT:
//   - mem_req = 0. On mem_data_ok: owner's data_ok = 1 and owner's rdata = mem_rdata,
//     both combinational in the same cycle; go to IDLE.
//   - The next grant can happen in that IDLE cycle, so there is one cycle of
//     turnaround between transactions.
//  Stray responses: mem_data_ok in IDLE, or in ADDR without mem_addr_ok, is ignored.
//   No *_ok output is asserted for it.
//  Non-owner: addr_ok = 0, data_ok = 0 and rdata = 0 at all times.
//  Request is committed at grant: deasserting the req after grant does not cancel the
//   transaction. A req that stays high after its addr_ok is a new request.
//  Reset mid-transaction: immediate return to IDLE; the outstanding response is lost.
//   The memory side must also be reset.
//  data_size = 3 is passed through unchanged; checking it is not this block's job.
// TESTING
//  1. Single read: inst_req, addr 0xBFC00000; mem_addr_ok at +2, mem_data_ok at +4 with
//     0x24080001 -> inst_addr_ok pulses at +2, inst_data_ok pulses at +4,
//     inst_rdata = 0x24080001, data_* stay 0.
//  2. Contention: inst_req and data_req (write 0x12345678 to 0x80000010, size 2) in the
//     same cycle -> data granted first with mem_wr = 1 and mem_addr = 0x80000010;
//     inst is granted after data_data_ok.
//  3. Starvation: data_req held high with inst_req high -> exactly 4 data grants,
//     then 1 inst grant, then data again.
//  4. Same-cycle response: mem_addr_ok and mem_data_ok together -> addr_ok and data_ok
//     both pulse that cycle; next grant in the following cycle.
//  5. Reset in WAIT: assert rst -> mem_req = 0, busy = 0, no *_ok asserted; after reset
//     release, a new inst_req is served normally.
//  6. Stray mem_data_ok in IDLE -> no *_ok output asserted, state stays IDLE.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one SRAM-like memory port between the instruction and data requesters.
// One transaction outstanding at a time; data has priority, with a starvation override for inst.
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inst_req,
  input  logic [AW-1:0] inst_addr,
  output logic          inst_addr_ok,
  output logic          inst_data_ok,
  output logic [DW-1:0] inst_rdata,
  input  logic          data_req,
  input  logic          data_wr,
  input  logic [1:0]    data_size,
  input  logic [AW-1:0] data_addr,
  input  logic [DW-1:0] data_wdata,
  output logic          data_addr_ok,
  output logic          data_data_ok,
  output logic [DW-1:0] data_rdata,
  output logic          mem_req,
  output logic          mem_wr,
  output logic [1:0]    mem_size,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_addr_ok,
  input  logic          mem_data_ok,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);
  // state | meaning
  // IDLE  | no transaction outstanding, arbitration happens here
  // ADDR  | request presented on the memory port, waiting for mem_addr_ok
  // WAIT  | request accepted, waiting for mem_data_ok

  typedef enum logic [1:0] {IDLE, ADDR, WAIT} state_t;

  localparam int SW = $clog2(STARVE_MAX + 1);

  state_t        state, nextState;
  logic          owner;
  logic [SW-1:0] starveCnt;
  logic          forceInst, grantInst, grantData;
  logic          addrAccept, respValid;

  assign forceInst = inst_req && (starveCnt == SW'(STARVE_MAX));

  always_comb begin
    nextState = state;
    grantInst = 1'b0;
    grantData = 1'b0;
    unique case (state)
      IDLE: begin
        if (forceInst)     grantInst = 1'b1;
        else if (data_req) grantData = 1'b1;
        else if (inst_req) grantInst = 1'b1;
        if (grantInst || grantData) nextState = ADDR;
      end
      ADDR: if (mem_addr_ok) nextState = mem_data_ok ? IDLE : WAIT;
      WAIT: if (mem_data_ok) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= 1'b0;
      starveCnt <= '0;
      mem_wr    <= 1'b0;
      mem_size  <= 2'd0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state <= nextState;
      if (grantInst) begin
        owner     <= 1'b0;
        starveCnt <= '0;
        mem_wr    <= 1'b0;
        mem_size  <= 2'd2;
        mem_addr  <= inst_addr;
        mem_wdata <= '0;
      end else if (grantData) begin
        owner     <= 1'b1;
        mem_wr    <= data_wr;
        mem_size  <= data_size;
        mem_addr  <= data_addr;
        mem_wdata <= data_wdata;
        // Saturating run length of data grants that passed over a waiting inst request
        if (!inst_req)                          starveCnt <= '0;
        else if (starveCnt != SW'(STARVE_MAX)) starveCnt <= starveCnt + SW'(1);
      end
    end
  end

  // Responses outside an accepted transaction (stray mem_data_ok) never reach a requester
  assign addrAccept = (state == ADDR) && mem_addr_ok;
  assign respValid  = mem_data_ok && (addrAccept || (state == WAIT));

  assign mem_req      = (state == ADDR);
  assign busy         = (state != IDLE);
  assign inst_addr_ok = addrAccept && !owner;
  assign data_addr_ok = addrAccept && owner;
  assign inst_data_ok = respValid && !owner;
  assign data_data_ok = respValid && owner;
  assign inst_rdata   = (respValid && !owner) ? mem_rdata : '0;
  assign data_rdata   = (respValid && owner) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios, then random traffic checked
// against a transaction-level model of the arbitration and handshake rules.
module tb_mem_port_arbiter;
  localparam int STARVE = 4;

  logic        clk, rst;
  logic        inst_req, inst_addr_ok, inst_data_ok;
  logic [31:0] inst_addr, inst_rdata;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok, busy;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int nAssert = 0;
  int nFail   = 0;

  // model: one outstanding transaction, whether its address phase is done, who owns it
  bit          mPend, mAcc, mOwner;
  int          mStarve;
  bit          mWr;
  logic [1:0]  mSize;
  logic [31:0] mAddr, mWdata;
  bit          eIA, eDA;

  mem_port_arbiter #(.AW(32), .DW(32), .STARVE_MAX(STARVE)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called just after inputs change: compare all outputs to the model, then advance the model
  task automatic step();
    bit eReq, eBusy, addrOk, dataOk;
    logic [31:0] eIRd, eDRd;
    #1;
    if (rst) begin
      mPend = 0; mAcc = 0; mOwner = 0; mStarve = 0;
      mWr = 0; mSize = 2'd0; mAddr = '0; mWdata = '0;
    end
    eReq   = mPend && !mAcc;
    eBusy  = mPend;
    addrOk = !rst && eReq && mem_addr_ok;
    dataOk = !rst && mPend && (mAcc || mem_addr_ok) && mem_data_ok;
    eIA    = addrOk && !mOwner;
    eDA    = addrOk && mOwner;
    eIRd   = (dataOk && !mOwner) ? mem_rdata : 32'd0;
    eDRd   = (dataOk && mOwner) ? mem_rdata : 32'd0;
    chk("mem_req", mem_req, eReq);
    chk("busy", busy, eBusy);
    chk("inst_addr_ok", inst_addr_ok, eIA);
    chk("data_addr_ok", data_addr_ok, eDA);
    chk("inst_data_ok", inst_data_ok, dataOk && !mOwner);
    chk("data_data_ok", data_data_ok, dataOk && mOwner);
    chk("inst_rdata", inst_rdata, eIRd);
    chk("data_rdata", data_rdata, eDRd);
    if (eReq || rst) begin
      chk("mem_wr", mem_wr, mWr);
      chk("mem_size", mem_size, mSize);
      chk("mem_addr", mem_addr, mAddr);
      chk("mem_wdata", mem_wdata, mWdata);
    end
    if (!rst) begin
      if (!mPend) begin
        if (inst_req && (mStarve == STARVE || !data_req)) begin
          mPend = 1; mAcc = 0; mOwner = 0; mStarve = 0;
          mWr = 0; mSize = 2'd2; mAddr = inst_addr; mWdata = '0;
        end else if (data_req) begin
          mPend = 1; mAcc = 0; mOwner = 1;
          mStarve = inst_req ? ((mStarve < STARVE) ? mStarve + 1 : STARVE) : 0;
          mWr = data_wr; mSize = data_size; mAddr = data_addr; mWdata = data_wdata;
        end
      end else if (!mAcc) begin
        if (mem_addr_ok) begin
          if (mem_data_ok) mPend = 0;
          else mAcc = 1;
        end
      end else if (mem_data_ok) begin
        mPend = 0;
      end
    end
  endtask

  task automatic cyc(input logic iq, input logic dq, input logic ao, input logic dk,
                     input logic [31:0] rd);
    @(negedge clk);
    inst_req = iq; data_req = dq; mem_addr_ok = ao; mem_data_ok = dk; mem_rdata = rd;
    step();
  endtask

  task automatic doReset(input logic dk);
    @(negedge clk);
    rst = 1'b1; inst_req = 0; data_req = 0; mem_addr_ok = 0; mem_data_ok = dk; mem_rdata = '0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    bit iPend, dPend;
    rst = 1'b1;
    inst_req = 0; inst_addr = '0; data_req = 0; data_wr = 0; data_size = 2'd0;
    data_addr = '0; data_wdata = '0; mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = '0;
    doReset(1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_mem_req", mem_req, 1'b0);

    // single instruction read
    inst_addr = 32'hBFC0_0000;
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk("t1_mem_addr", mem_addr, 32'hBFC0_0000);
    cyc(1, 0, 1, 0, 0);
    chk("t1_inst_addr_ok", inst_addr_ok, 1'b1);
    cyc(0, 0, 0, 0, 0);
    chk("t1_wait_busy", busy, 1'b1);
    cyc(0, 0, 0, 1, 32'h2408_0001);
    chk("t1_inst_data_ok", inst_data_ok, 1'b1);
    chk("t1_inst_rdata", inst_rdata, 32'h2408_0001);
    chk("t1_data_rdata", data_rdata, 32'd0);

    // contention: data write wins, then inst with same-cycle addr/data response
    inst_addr = 32'hBFC0_0004;
    data_wr = 1; data_size = 2'd2; data_addr = 32'h8000_0010; data_wdata = 32'h1234_5678;
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    chk("t2_mem_wr", mem_wr, 1'b1);
    chk("t2_mem_addr", mem_addr, 32'h8000_0010);
    chk("t2_mem_wdata", mem_wdata, 32'h1234_5678);
    cyc(1, 1, 1, 0, 0);
    chk("t2_data_addr_ok", data_addr_ok, 1'b1);
    cyc(1, 0, 0, 1, 32'hCAFE_0000);
    chk("t2_data_data_ok", data_data_ok, 1'b1);
    cyc(1, 0, 0, 0, 0);
    chk("t2_turnaround_busy", busy, 1'b0);
    cyc(1, 0, 0, 0, 0);
    chk("t2_inst_mem_addr", mem_addr, 32'hBFC0_0004);
    chk("t2_inst_mem_wr", mem_wr, 1'b0);
    chk("t2_inst_mem_size", mem_size, 2'd2);
    cyc(0, 1, 1, 1, 32'h0000_00AB);
    chk("t4_same_addr_ok", inst_addr_ok, 1'b1);
    chk("t4_same_data_ok", inst_data_ok, 1'b1);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    chk("t4_next_grant", mem_req, 1'b1);
    cyc(0, 0, 1, 1, 0);

    // starvation: both held high -> 4 data grants, 1 inst, then data again
    doReset(1'b0);
    data_wr = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(1, 1, 0, 0, 0);
      cyc(1, 1, 1, 1, $urandom);
      chk("t3_grant_is_data", data_addr_ok, (i != 4));
      chk("t3_grant_is_inst", inst_addr_ok, (i == 4));
    end

    // reset while waiting for the response
    doReset(1'b0);
    inst_addr = 32'hBFC0_0100;
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0);
    doReset(1'b1);
    chk("t5_mem_req", mem_req, 1'b0);
    chk("t5_busy", busy, 1'b0);
    chk("t5_inst_data_ok", inst_data_ok, 1'b0);
    cyc(0, 0, 0, 1, 32'h5555_5555);
    chk("t5_after_stray", inst_data_ok, 1'b0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 1, 1, 32'h1111_2222);
    chk("t5_served_rdata", inst_rdata, 32'h1111_2222);

    // stray response in IDLE
    cyc(0, 0, 0, 1, 32'hDEAD_BEEF);
    chk("t6_inst_data_ok", inst_data_ok, 1'b0);
    chk("t6_data_data_ok", data_data_ok, 1'b0);
    cyc(0, 0, 0, 0, 0);
    chk("t6_still_idle", busy, 1'b0);

    // random traffic; requesters hold req until their addr_ok
    iPend = 0; dPend = 0;
    for (int n = 0; n < 800; n++) begin
      @(negedge clk);
      if ($urandom_range(0, 149) == 0) begin
        rst = 1'b1; iPend = 0; dPend = 0;
      end else rst = 1'b0;
      if (!iPend && $urandom_range(0, 2) == 0) begin
        iPend = 1; inst_addr = $urandom;
      end
      if (!dPend && $urandom_range(0, 1) == 0) begin
        dPend = 1; data_addr = $urandom; data_wdata = $urandom;
        data_wr = $urandom_range(0, 1); data_size = 2'($urandom_range(0, 3));
      end
      inst_req = iPend; data_req = dPend;
      mem_addr_ok = $urandom_range(0, 1);
      mem_data_ok = ($urandom_range(0, 2) == 0);
      mem_rdata = $urandom;
      step();
      if (eIA) iPend = 0;
      if (eDA) dPend = 0;
    end
    @(negedge clk);
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end
endmodule
